// File: rtl/fp_pkg.sv
// fp_pkg: shared types and constants for the single-precision
// floating-point multiplier and divider.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;
    localparam int QBITS  = 25;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, PREP, DIV, NORM} state_t;

    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

    // Denormals (exponent 0) are treated as zero.
    function automatic special_t classify(
        input logic [EXP_W-1:0] ea,
        input logic [EXP_W-1:0] eb
    );
        special_t sp;
        sp = SP_NONE;
        if (ea == '1 || eb == '1)
            sp = SP_NAN;
        else if (ea == '0 && eb == '0)
            sp = SP_NAN;
        else if (eb == '0)
            sp = SP_INF;
        else if (ea == '0)
            sp = SP_ZERO;
        return sp;
    endfunction

endpackage

// File: rtl/fp_mant_div_step.sv
// fp_mant_div_step: one restoring division step, producing a quotient
// bit and the shifted partial remainder for the next iteration.
module fp_mant_div_step #(
    parameter int RW = 25,
    parameter int DW = 24
) (
    input  logic [RW-1:0] rem,
    input  logic [DW-1:0] div,
    output logic [RW-1:0] rem_next,
    output logic          q_bit
);

    logic [RW-1:0] div_ext;
    logic [RW-1:0] diff;

    assign div_ext  = RW'(div);
    assign q_bit    = (rem >= div_ext);
    assign diff     = q_bit ? rem - div_ext : rem;
    assign rem_next = diff << 1;

endmodule

// File: rtl/fp_divider_seq.sv
// fp_divider_seq: iterative IEEE-754 single-precision divider using
// restoring mantissa division behind a start/done handshake.
module fp_divider_seq
    import fp_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        start,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow
);

    localparam int DW = MANT_W + 1;

    state_t            state_q, state_d;
    special_t          special_q, special_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic              sign_q, sign_d;
    logic signed [9:0] exp_tmp_q, exp_tmp_d;
    logic [QBITS-1:0]  rem_q, rem_d;
    logic [QBITS-1:0]  quo_q, quo_d;
    logic [DW-1:0]     div_q, div_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       result_q, result_d;
    logic              exc_q, exc_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [QBITS-1:0]  rem_step;
    logic              q_bit;
    logic signed [9:0] exp_n;
    logic [MANT_W-1:0] mant_n;

    fp_mant_div_step #(
        .RW(QBITS),
        .DW(DW)
    ) u_step (
        .rem     (rem_q),
        .div     (div_q),
        .rem_next(rem_step),
        .q_bit   (q_bit)
    );

    // Mantissa ratio lies in (0.5, 2): at most one normalising shift.
    assign exp_n  = quo_q[QBITS-1] ? exp_tmp_q : exp_tmp_q - 10'sd1;
    assign mant_n = quo_q[QBITS-1] ? quo_q[QBITS-2:1] : quo_q[QBITS-3:0];

    always_comb begin
        state_d   = state_q;
        special_d = special_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        exp_tmp_d = exp_tmp_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        exc_d     = exc_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_operand;
                    b_d     = b_operand;
                    busy_d  = 1'b1;
                    exc_d   = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = PREP;
                end
            end
            PREP: begin
                sign_d    = a_q[31] ^ b_q[31];
                exp_tmp_d = signed'(10'(a_q[30:23]) - 10'(b_q[30:23])
                                    + 10'(BIAS));
                special_d = classify(a_q[30:23], b_q[30:23]);
                rem_d     = QBITS'({1'b1, a_q[22:0]});
                div_d     = {1'b1, b_q[22:0]};
                quo_d     = '0;
                cnt_d     = 5'(QBITS - 1);
                state_d   = DIV;
            end
            DIV: begin
                rem_d = rem_step;
                quo_d = {quo_q[QBITS-2:0], q_bit};
                if (cnt_q == '0)
                    state_d = NORM;
                else
                    cnt_d = cnt_q - 5'd1;
            end
            NORM: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                unique case (special_q)
                    SP_NAN: begin
                        result_d = QNAN;
                        exc_d    = 1'b1;
                    end
                    SP_INF: begin
                        result_d = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                        exc_d    = 1'b1;
                    end
                    SP_ZERO: begin
                        result_d = {sign_q, 31'h0};
                    end
                    SP_NONE: begin
                        if (exp_n >= 10'sd255) begin
                            result_d = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                            ovf_d    = 1'b1;
                        end else if (exp_n <= 10'sd0) begin
                            result_d = {sign_q, 31'h0};
                            unf_d    = 1'b1;
                        end else begin
                            result_d = {sign_q, exp_n[7:0], mant_n};
                        end
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            special_q <= SP_NONE;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            exp_tmp_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            special_q <= special_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sign_q    <= sign_d;
            exp_tmp_q <= exp_tmp_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign Exception = exc_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

endmodule

// File: tb/tb_fp_divider_seq.sv
// tb_fp_divider_seq: directed vectors against literal expectations plus
// a per-cycle comparison with an arithmetic reference model.
module tb_fp_divider_seq;

    logic        CLK;
    logic        RESET_N;
    logic        start;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        Exception;
    logic        Overflow;
    logic        Underflow;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // reference model state
    bit          m_busy;
    bit          m_done;
    int          m_edges;
    logic [31:0] m_res;
    logic [2:0]  m_flags;
    logic [34:0] m_pend;

    fp_divider_seq dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .start    (start),
        .a_operand(a_operand),
        .b_operand(b_operand),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .Exception(Exception),
        .Overflow (Overflow),
        .Underflow(Underflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns {Exception, Overflow, Underflow, result} from the
    // arithmetic definition of the truncated quotient.
    function automatic logic [34:0] model(input logic [31:0] a,
                                          input logic [31:0] b);
        logic        s;
        int          ea;
        int          eb;
        int          e;
        longint      na;
        longint      nb;
        longint      q;
        logic [22:0] m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255)
            return {3'b100, 32'h7FC00000};
        if (ea == 0 && eb == 0)
            return {3'b100, 32'h7FC00000};
        if (eb == 0)
            return {3'b100, s, 8'hFF, 23'h0};
        if (ea == 0)
            return {3'b000, s, 31'h0};
        na = longint'({1'b1, a[22:0]});
        nb = longint'({1'b1, b[22:0]});
        q  = (na << 24) / nb;
        e  = ea - eb + 127;
        if (q >= 64'd16777216) begin
            m = 23'(q >> 1);
        end else begin
            m = 23'(q);
            e = e - 1;
        end
        if (e >= 255)
            return {3'b010, s, 8'hFF, 23'h0};
        if (e <= 0)
            return {3'b001, s, 31'h0};
        return {3'b000, s, 8'(e), m};
    endfunction

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_busy  = 0;
            m_done  = 0;
            m_edges = 0;
            m_res   = '0;
            m_flags = '0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_edges++;
                if (m_edges == 27) begin
                    m_busy  = 0;
                    m_done  = 1;
                    m_res   = m_pend[31:0];
                    m_flags = m_pend[34:32];
                end
            end else if (start) begin
                m_busy  = 1;
                m_edges = 0;
                m_flags = '0;
                m_pend  = model(a_operand, b_operand);
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("cyc busy", 32'(busy), 32'(m_busy));
            check("cyc done", 32'(done), 32'(m_done));
            check("cyc flags", 32'({Exception, Overflow, Underflow}),
                  32'(m_flags));
            if (!m_busy)
                check("cyc result", result, m_res);
        end
    end

    task automatic run(input string name, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic [2:0] exp_fl);
        logic [34:0] mv;
        int          k;
        mv = model(a, b);
        check({name, " model"}, mv[31:0], exp_res);
        check({name, " model flags"}, 32'(mv[34:32]), 32'(exp_fl));
        @(negedge CLK);
        a_operand = a;
        b_operand = b;
        start     = 1'b1;
        k         = 0;
        do begin
            @(negedge CLK);
            k++;
            if (k == 1)
                start = 1'b0;
        end while (!done && k < 40);
        check({name, " latency"}, 32'(k), 32'd28);
        check({name, " result"}, result, exp_res);
        check({name, " flags"}, 32'({Exception, Overflow, Underflow}),
              32'(exp_fl));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dn;
        RESET_N   = 1'b0;
        start     = 1'b0;
        a_operand = '0;
        b_operand = '0;
        @(negedge CLK);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", result, 32'd0);
        check("rst flags", 32'({Exception, Overflow, Underflow}), 32'd0);
        RESET_N = 1'b1;
        chk_en  = 1;

        run("5/5", 32'h40A00000, 32'h40A00000, 32'h3F800000, 3'b000);
        run("6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000);
        run("1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000);
        run("1/0", 32'h3F800000, 32'h00000000, 32'h7F800000, 3'b100);
        run("0/0", 32'h00000000, 32'h00000000, 32'h7FC00000, 3'b100);
        run("ovf", 32'h7F000000, 32'h00800000, 32'h7F800000, 3'b010);
        run("unf", 32'h00800000, 32'h7F000000, 32'h00000000, 3'b001);
        run("-6/2", 32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000);
        run("inf/1", 32'h7F800000, 32'h3F800000, 32'h7FC00000, 3'b100);
        run("0/2", 32'h00000000, 32'h40000000, 32'h00000000, 3'b000);
        run("-0/2", 32'h80000000, 32'h40000000, 32'h80000000, 3'b000);
        run("trunc", 32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 3'b000);
        run("den a", 32'h00400000, 32'h3F800000, 32'h00000000, 3'b000);
        run("den b", 32'h3F800000, 32'h00000001, 32'h7F800000, 3'b100);
        run("exp255", 32'h7F000000, 32'h3F000000, 32'h7F800000, 3'b010);
        run("exp1", 32'h00800000, 32'h3F800000, 32'h00800000, 3'b000);
        run("exp0", 32'h00800000, 32'h3FC00000, 32'h00000000, 3'b001);

        // start while busy is ignored
        @(negedge CLK);
        a_operand = 32'h40C00000;
        b_operand = 32'h40000000;
        start     = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        a_operand = 32'h3F800000;
        b_operand = 32'h40400000;
        start     = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        dn    = 0;
        repeat (40) begin
            @(negedge CLK);
            if (done)
                dn++;
        end
        check("busy start dones", 32'(dn), 32'd1);
        check("busy start result", result, 32'h40400000);

        // reset in the middle of a divide
        @(negedge CLK);
        a_operand = 32'h40A00000;
        b_operand = 32'h40A00000;
        start     = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (9) @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", result, 32'd0);
        check("abort flags", 32'({Exception, Overflow, Underflow}), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        dn      = 0;
        repeat (35) begin
            @(negedge CLK);
            if (done)
                dn++;
        end
        check("abort dones", 32'(dn), 32'd0);
        run("6/2 post", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000);

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
